mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store in the 5-stage MIPS pipeline. Each access is sequenced through a fixed-latency RAM. Stall outputs feed the pipeline controller's stage enables. MEM-stage requests take priority because they belong to the older instruction.

## Interface
Parameters:
- ADDR_W, 10: RAM word-address width.
- RAM_LAT, 1: RAM read latency in cycles, ≥1.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  instruction fetch request (level, held until ack)
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction
- if_ack  out  1  one-cycle completion pulse for IF
- if_stall  out  1  if_req & ~if_ack
- mem_ren  in  1  load request
- mem_wen  in  1  store request
- mem_addr  in  32  load/store byte address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data
- mem_ack  out  1  one-cycle completion pulse for MEM
- mem_stall  out  1  (mem_ren|mem_wen) & ~mem_ack
- ram_cs  out  1  RAM chip select, one cycle per access
- ram_we  out  1  RAM write enable, qualified by ram_cs
- ram_addr  out  ADDR_W  RAM word address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, valid RAM_LAT cycles after the ram_cs cycle

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE: if mem_ren|mem_wen, go to BUSY_MEM; else if if_req, go to BUSY_IF; else stay. Address, we and wdata are latched at the transition.
- Both requests are present in IDLE: MEM is granted. IF is granted at the next IDLE.
- mem_ren and mem_wen are both high: the access is a write.
- BUSY_x: the down-counter loads RAM_LAT on entry and decrements each cycle. At count 0, ram_dout is captured into the owner's rdata register and the state goes to DONE.
- DONE: the owner's ack is high for exactly one cycle, then the state goes to IDLE. No new grant is made in DONE.
- Writes: ack timing is the same as reads. mem_rdata holds its previous value.
- ram_addr = addr[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so addresses alias modulo 4·2^ADDR_W bytes.
- Requester rule: the request is dropped or changed on the edge that samples ack. A request still held after ack starts a new access.
- if_rdata and mem_rdata are registered and hold their value until the next completed read of the same port.

## Timing
- Reset values: state IDLE, counter 0, ram_cs 0, ram_we 0, ram_addr 0, ram_din 0, if_ack 0, mem_ack 0, if_rdata 0, mem_rdata 0.
- Stalls follow the request combinationally, so their reset value is determined by the inputs.
- Cycle numbering, with the request first seen in IDLE at cycle 0:
  - Cycle 1: ram_cs is high.
  - Cycle 1+RAM_LAT: ram_dout is valid.
  - Cycle 2+RAM_LAT: ack is high.
  - Cycle 3+RAM_LAT: the block is in IDLE again.
- Request-to-ack latency is RAM_LAT+2. Back-to-back throughput is one access per RAM_LAT+3 cycles.
- Losing IF request: it stalls for the entire MEM access plus its own access.
- rst in any state: the in-flight access is abandoned, all registers go to their reset values on that edge, and requests are ignored while rst is high.
- All outputs except the stalls are registered.

## Configuration
- MEM_ARB_PERF_EN defined: adds three output ports perf_if_cnt, perf_mem_cnt and perf_conflict_cnt, each 32 bits.
  - perf_if_cnt: +1 per if_ack.
  - perf_mem_cnt: +1 per mem_ack.
  - perf_conflict_cnt: +1 per IDLE cycle in which both requests are present.
  - The counters wrap at 2^32 and are cleared by rst.
- MEM_ARB_PERF_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- define.vh holds the state encodings ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_MEM and ARB_DONE (2 bits), plus the owner encoding.
- Sub-module arb_perf_counter: a 32-bit wrapping counter with rst and inc inputs. It is instantiated three times under MEM_ARB_PERF_EN.

## Test plan
- IF only, RAM_LAT=1: if_req=1, if_addr=0x0000_0010, ram_dout=0x2001_0005 → ram_cs high in cycle 1 with ram_addr=4, if_ack in cycle 3, if_rdata=0x2001_0005.
- Simultaneous: if_req=1 and mem_ren=1 at cycle 0 → MEM is served first (mem_ack in cycle 3). IF has ram_cs in cycle 5 and if_ack in cycle 7. if_stall is high in cycles 0–6. perf_conflict_cnt=1.
- Store: mem_wen=1, mem_addr=0x0000_0104, mem_wdata=0xDEAD_BEEF → cycle 1 has ram_cs=1, ram_we=1, ram_addr=0x41, ram_din=0xDEAD_BEEF. mem_rdata is unchanged.
- RAM_LAT=3: load → ack in cycle 5, data sampled from ram_dout in cycle 4.
- Reset mid-access: rst in cycle 2 of an IF access → no if_ack ever. The block is IDLE with all outputs 0 in cycle 3. A request after rst falls is served normally.
- Address wrap, ADDR_W=10: mem_addr=0x0000_1008 → ram_addr=2.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and access owner.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_IF  = 2'd1,
    ARB_BUSY_MEM = 2'd2,
    ARB_DONE     = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_t;

  // Latency counter must hold the value RAM_LAT itself.
  function automatic int lat_cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/arb_perf_counter.sv
// 32-bit wrapping event counter, cleared by rst; only present with MEM_ARB_PERF_EN.
// Latency: count visible the cycle after inc; no backpressure.
`ifdef MEM_ARB_PERF_EN
module arb_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// IF/MEM arbiter for one single-port RAM, MEM wins ties; MEM_ARB_PERF_EN adds perf counters.
// Latency: request-to-ack RAM_LAT+2; loser is held off via its stall until the winner completes.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ack,
  output logic              mem_stall,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_mem_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);

  localparam int               CNT_W    = lat_cnt_w(RAM_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT);

  arb_state_t       state;
  arb_owner_t       owner;
  logic [CNT_W-1:0] cnt;
  logic             wr;
  logic             mem_req;

  assign mem_req   = mem_ren | mem_wen;
  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

  // Byte-lane and above-RAM address bits alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_IF;
      cnt       <= '0;
      wr        <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      ram_cs  <= 1'b0;
      ram_we  <= 1'b0;
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (mem_req) begin
            state    <= ARB_BUSY_MEM;
            owner    <= OWN_MEM;
            cnt      <= CNT_LOAD;
            wr       <= mem_wen;
            ram_cs   <= 1'b1;
            ram_we   <= mem_wen;
            ram_addr <= mem_addr[ADDR_W+1:2];
            ram_din  <= mem_wdata;
          end else if (if_req) begin
            state    <= ARB_BUSY_IF;
            owner    <= OWN_IF;
            cnt      <= CNT_LOAD;
            wr       <= 1'b0;
            ram_cs   <= 1'b1;
            ram_addr <= if_addr[ADDR_W+1:2];
          end
        end
        ARB_BUSY_IF, ARB_BUSY_MEM: begin
          if (cnt == '0) begin
            state <= ARB_DONE;
            if (owner == OWN_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= ram_dout;
            end else begin
              mem_ack <= 1'b1;
              if (!wr) begin
                mem_rdata <= ram_dout;
              end
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          // DONE: ack is out this cycle, no new grant until IDLE.
          state <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic conflict;
  assign conflict = (state == ARB_IDLE) & if_req & mem_req;

  arb_perf_counter u_perf_if (
    .clk (clk),
    .rst (rst),
    .inc (if_ack),
    .cnt (perf_if_cnt)
  );

  arb_perf_counter u_perf_mem (
    .clk (clk),
    .rst (rst),
    .inc (mem_ack),
    .cnt (perf_mem_cnt)
  );

  arb_perf_counter u_perf_conflict (
    .clk (clk),
    .rst (rst),
    .inc (conflict),
    .cnt (perf_conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RAM_LAT 1 and 3) each behind a behavioural RAM.
// Expected data comes from a word-array memory model; expected timing from latency arithmetic.
module tb_mem_arbiter;

  localparam int NDUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NDUT];
  logic        if_req    [NDUT];
  logic [31:0] if_addr   [NDUT];
  logic [31:0] if_rdata  [NDUT];
  logic        if_ack    [NDUT];
  logic        if_stall  [NDUT];
  logic        mem_ren   [NDUT];
  logic        mem_wen   [NDUT];
  logic [31:0] mem_addr  [NDUT];
  logic [31:0] mem_wdata [NDUT];
  logic [31:0] mem_rdata [NDUT];
  logic        mem_ack   [NDUT];
  logic        mem_stall [NDUT];
  logic        ram_cs    [NDUT];
  logic        ram_we    [NDUT];
  logic [9:0]  ram_addr  [NDUT];
  logic [31:0] ram_din   [NDUT];
  logic [31:0] ram_dout  [NDUT];
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_cnt       [NDUT];
  logic [31:0] perf_mem_cnt      [NDUT];
  logic [31:0] perf_conflict_cnt [NDUT];
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NDUT][1024];
  int pool [16];

  for (genvar g = 0; g < NDUT; g++) begin : gi
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0]    ram [1024];
    logic [LAT-1:0] pv;
    logic [31:0]    pd [LAT];

    mem_arbiter #(.ADDR_W(10), .RAM_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_rdata  (if_rdata[g]),
      .if_ack    (if_ack[g]),
      .if_stall  (if_stall[g]),
      .mem_ren   (mem_ren[g]),
      .mem_wen   (mem_wen[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .mem_ack   (mem_ack[g]),
      .mem_stall (mem_stall[g]),
      .ram_cs    (ram_cs[g]),
      .ram_we    (ram_we[g]),
      .ram_addr  (ram_addr[g]),
      .ram_din   (ram_din[g]),
      .ram_dout  (ram_dout[g])
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_if_cnt       (perf_if_cnt[g]),
      .perf_mem_cnt      (perf_mem_cnt[g]),
      .perf_conflict_cnt (perf_conflict_cnt[g])
`endif
    );

    // Read data is valid only in the single cycle RAM_LAT after the select.
    always @(posedge clk) begin
      if (ram_cs[g] && ram_we[g]) ram[ram_addr[g]] <= ram_din[g];
      pv[0] <= ram_cs[g] && !ram_we[g];
      pd[0] <= ram[ram_addr[g]];
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
    assign ram_dout[g] = pv[LAT-1] ? pd[LAT-1] : 32'hDEAD_0BAD;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic logic [31:0] rand_addr(input int w);
    return ($urandom & 32'hFFFF_F003) | (32'(w) << 2);
  endfunction

  task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL dut%0d.%s: observed %h expected %h", k, tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input int k, input string pfx);
    chk(k, {pfx, "_ram_cs"},    32'(ram_cs[k]),    0);
    chk(k, {pfx, "_ram_we"},    32'(ram_we[k]),    0);
    chk(k, {pfx, "_ram_addr"},  32'(ram_addr[k]),  0);
    chk(k, {pfx, "_ram_din"},   ram_din[k],        0);
    chk(k, {pfx, "_if_ack"},    32'(if_ack[k]),    0);
    chk(k, {pfx, "_mem_ack"},   32'(mem_ack[k]),   0);
    chk(k, {pfx, "_if_rdata"},  if_rdata[k],       0);
    chk(k, {pfx, "_mem_rdata"}, mem_rdata[k],      0);
    chk(k, {pfx, "_if_stall"},  32'(if_stall[k]),  0);
    chk(k, {pfx, "_mem_stall"}, 32'(mem_stall[k]), 0);
`ifdef MEM_ARB_PERF_EN
    chk(k, {pfx, "_perf_if"},   perf_if_cnt[k],       0);
    chk(k, {pfx, "_perf_mem"},  perf_mem_cnt[k],      0);
    chk(k, {pfx, "_perf_conf"}, perf_conflict_cnt[k], 0);
`endif
  endtask

  // One access with the arbiter idle: cycle 0 is the current cycle.
  task automatic access(input int k, input bit is_if, input bit ren, input bit wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int c;
    int w;
    bit got;
    bit wr;
    logic [31:0] rd;
    logic [31:0] prev;
    wr   = !is_if && wen;
    w    = widx(addr);
    prev = mem_rdata[k];
    got  = 1'b0;
    c    = 0;
    rd   = '0;
    if (is_if) begin
      if_req[k]  = 1'b1;
      if_addr[k] = addr;
    end else begin
      mem_ren[k]   = ren;
      mem_wen[k]   = wen;
      mem_addr[k]  = addr;
      mem_wdata[k] = wdata;
    end
    while (!got && c < 50) begin
      @(negedge clk);
      if (c == 0) chk(k, "stall_c0", 32'(is_if ? if_stall[k] : mem_stall[k]), 1);
      if (c == 1) begin
        chk(k, "ram_cs_c1",   32'(ram_cs[k]),   1);
        chk(k, "ram_we_c1",   32'(ram_we[k]),   32'(wr));
        chk(k, "ram_addr_c1", 32'(ram_addr[k]), 32'(w));
        if (wr) chk(k, "ram_din_c1", ram_din[k], wdata);
      end
      if (is_if ? if_ack[k] : mem_ack[k]) begin
        got = 1'b1;
        rd  = is_if ? if_rdata[k] : mem_rdata[k];
        chk(k, "stall_at_ack", 32'(is_if ? if_stall[k] : mem_stall[k]), 0);
      end
      next_cycle();
      if (!got) c++;
    end
    if_req[k]  = 1'b0;
    mem_ren[k] = 1'b0;
    mem_wen[k] = 1'b0;
    chk(k, "ack_latency", got ? 32'(c) : 32'hFFFF_FFFF, 32'(lat_of(k) + 2));
    if (wr) begin
      model[k][w] = wdata;
      chk(k, "mem_rdata_hold_on_store", rd, prev);
    end else begin
      chk(k, is_if ? "if_rdata" : "mem_rdata", rd, model[k][w]);
    end
  endtask

  // IF fetch and MEM load raised in the same idle cycle.
  task automatic sim_pair(input int k, input logic [31:0] ia_addr, input logic [31:0] ma_addr);
    int c, ma, ia, cs2, ncs, stall_n, lat;
    logic [31:0] mrd, ird;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] conf0, if0, mem0;
    conf0 = perf_conflict_cnt[k];
    if0   = perf_if_cnt[k];
    mem0  = perf_mem_cnt[k];
`endif
    lat = lat_of(k);
    c = 0; ma = -1; ia = -1; cs2 = -1; ncs = 0; stall_n = 0;
    mrd = '0; ird = '0;
    if_req[k]   = 1'b1;
    if_addr[k]  = ia_addr;
    mem_ren[k]  = 1'b1;
    mem_addr[k] = ma_addr;
    while (ia < 0 && c < 60) begin
      @(negedge clk);
      if (if_stall[k]) stall_n++;
      if (ram_cs[k]) begin
        ncs++;
        if (ncs == 2) cs2 = c;
      end
      if (mem_ack[k] && ma < 0) begin
        ma  = c;
        mrd = mem_rdata[k];
      end
      if (if_ack[k]) begin
        ia  = c;
        ird = if_rdata[k];
      end
      next_cycle();
      if (ma == c) mem_ren[k] = 1'b0;
      c++;
    end
    if_req[k]  = 1'b0;
    mem_ren[k] = 1'b0;
    chk(k, "pair_mem_ack_cycle", 32'(ma),      32'(lat + 2));
    chk(k, "pair_if_ack_cycle",  32'(ia),      32'(2 * lat + 5));
    chk(k, "pair_if_cs_cycle",   32'(cs2),     32'(lat + 4));
    chk(k, "pair_if_stall_cyc",  32'(stall_n), 32'(2 * lat + 5));
    chk(k, "pair_mem_rdata",     mrd,          model[k][widx(ma_addr)]);
    chk(k, "pair_if_rdata",      ird,          model[k][widx(ia_addr)]);
`ifdef MEM_ARB_PERF_EN
    chk(k, "pair_perf_conflict", perf_conflict_cnt[k] - conf0, 1);
    chk(k, "pair_perf_if",       perf_if_cnt[k] - if0,         1);
    chk(k, "pair_perf_mem",      perf_mem_cnt[k] - mem0,       1);
`endif
  endtask

  task automatic reset_mid(input int k);
    int acks;
    if_req[k]  = 1'b1;
    if_addr[k] = 32'h0000_0010;
    next_cycle();
    @(negedge clk);
    chk(k, "rstmid_cs_c1", 32'(ram_cs[k]), 1);
    next_cycle();
    rst[k] = 1'b1;
    next_cycle();
    rst[k]    = 1'b0;
    if_req[k] = 1'b0;
    @(negedge clk);
    chk_zero_outputs(k, "rstmid");
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      @(negedge clk);
      if (if_ack[k]) acks++;
    end
    chk(k, "rstmid_no_if_ack", 32'(acks), 0);
    next_cycle();
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1;
      if_req[k] = 1'b0;  if_addr[k] = '0;
      mem_ren[k] = 1'b0; mem_wen[k] = 1'b0;
      mem_addr[k] = '0;  mem_wdata[k] = '0;
    end
    for (int i = 0; i < 16; i++) pool[i] = (i * 67 + 3) % 1024;
    repeat (3) next_cycle();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk_zero_outputs(k, "reset");
    next_cycle();
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;

    // RAM_LAT=1 directed steps
    access(0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h2001_0005);
    access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    chk(0, "if_fetch_word4", if_rdata[0], 32'h2001_0005);
    access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    access(0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
    access(0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D);
    access(0, 1'b0, 1'b0, 1'b1, 32'h0000_1008, 32'h1234_5678);
    access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    chk(0, "wrap_alias_word2", mem_rdata[0], 32'h1234_5678);
    sim_pair(0, 32'h0000_0010, 32'h0000_0104);
    reset_mid(0);
    access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);

    // RAM_LAT=3 directed steps
    access(1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_0001);
    access(1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    access(1, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0BAD_CAFE);
    sim_pair(1, 32'h0000_0044, 32'h0000_0040);

    // Randomized traffic over a pool of words, each word written first
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 16; i++)
        access(k, 1'b0, 1'b0, 1'b1, rand_addr(pool[i]), $urandom);
      for (int n = 0; n < 30; n++) begin
        int sel;
        logic [31:0] a1, a2;
        sel = $urandom_range(0, 4);
        a1  = rand_addr(pool[$urandom_range(0, 15)]);
        a2  = rand_addr(pool[$urandom_range(0, 15)]);
        case (sel)
          0:       access(k, 1'b1, 1'b0, 1'b0, a1, 32'h0);
          1:       access(k, 1'b0, 1'b1, 1'b0, a1, 32'h0);
          2:       access(k, 1'b0, 1'b0, 1'b1, a1, $urandom);
          3:       access(k, 1'b0, 1'b1, 1'b1, a1, $urandom);
          default: sim_pair(k, a1, a2);
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
